// File: rtl/syzygy_dac_playback_ctrl.sv
// Owns the single-port 1024x12 SYZYGY DAC waveform BRAM: streams a host waveform in (LOAD)
// and replays it to the DAC PHY for N loops or forever (PLAY), converting to offset binary.
module syzygy_dac_playback_ctrl #(
   parameter int RD_LAT = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        locked_i,
   input  logic        rst_busy_i,
   input  logic [9:0]  cfg_last_i,
   input  logic [15:0] cfg_loops_i,
   input  logic        load_start_i,
   input  logic        play_start_i,
   input  logic        stop_i,
   input  logic [11:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic        bram_en_o,
   output logic        bram_we_o,
   output logic [9:0]  bram_addr_o,
   output logic [11:0] bram_din_o,
   input  logic [11:0] bram_dout_i,
   output logic [11:0] dac_data_o,
   output logic        dac_valid_o,
   output logic        busy_o,
   output logic        load_done_o,
   output logic        play_done_o,
   output logic [10:0] load_count_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_PLAY  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  last_q, last_d;
   logic [15:0] loops_q, loops_d;
   logic [9:0]  rptr_q, rptr_d;
   logic [15:0] loop_cnt_q, loop_cnt_d;
   logic [10:0] load_count_q, load_count_d;
   logic [1:0]  drain_cnt_q, drain_cnt_d;
   logic        load_done_q, load_done_d;
   logic        play_done_q, play_done_d;
   logic        rd_issue;
   logic        ok;
   logic [RD_LAT-1:0] rv_q, rv_d;

   assign ok = locked_i && !rst_busy_i;

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      loops_d      = loops_q;
      rptr_d       = rptr_q;
      loop_cnt_d   = loop_cnt_q;
      load_count_d = load_count_q;
      drain_cnt_d  = drain_cnt_q;
      load_done_d  = 1'b0;
      play_done_d  = 1'b0;
      rd_issue     = 1'b0;
      s_ready_o    = 1'b0;
      bram_en_o    = 1'b0;
      bram_we_o    = 1'b0;
      bram_addr_o  = 10'd0;
      bram_din_o   = 12'd0;

      case (state_q)
         S_IDLE: begin
            if (load_start_i) begin
               state_d      = S_LOAD;
               last_d       = cfg_last_i;
               load_count_d = 11'd0;
            end else if (play_start_i) begin
               state_d    = S_PLAY;
               last_d     = cfg_last_i;
               loops_d    = cfg_loops_i;
               rptr_d     = 10'd0;
               loop_cnt_d = 16'd0;
            end
         end

         S_LOAD: begin
            s_ready_o = ok;
            // The low ten bits of load_count double as the write pointer.
            if (ok && s_valid_i) begin
               bram_en_o    = 1'b1;
               bram_we_o    = 1'b1;
               bram_addr_o  = load_count_q[9:0];
               bram_din_o   = s_data_i;
               load_count_d = load_count_q + 11'd1;
               if (load_count_q[9:0] == last_q) begin
                  state_d     = S_IDLE;
                  load_done_d = !stop_i;
               end
            end
            if (stop_i) begin
               state_d = S_IDLE;
            end
         end

         S_PLAY: begin
            if (ok) begin
               bram_en_o   = 1'b1;
               bram_addr_o = rptr_q;
               rd_issue    = 1'b1;
               if (rptr_q == last_q) begin
                  rptr_d     = 10'd0;
                  loop_cnt_d = loop_cnt_q + 16'd1;
                  if ((loops_q != 16'd0) && (loop_cnt_q + 16'd1 == loops_q)) begin
                     state_d     = S_DRAIN;
                     drain_cnt_d = 2'd0;
                  end
               end else begin
                  rptr_d = rptr_q + 10'd1;
               end
            end
            if (stop_i) begin
               state_d     = S_DRAIN;
               drain_cnt_d = 2'd0;
            end
         end

         S_DRAIN: begin
            // Hold long enough for the final read to leave the BRAM pipeline.
            if (drain_cnt_q == 2'(RD_LAT - 1)) begin
               state_d     = S_IDLE;
               play_done_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         last_q       <= 10'd0;
         loops_q      <= 16'd0;
         rptr_q       <= 10'd0;
         loop_cnt_q   <= 16'd0;
         load_count_q <= 11'd0;
         drain_cnt_q  <= 2'd0;
         load_done_q  <= 1'b0;
         play_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         loops_q      <= loops_d;
         rptr_q       <= rptr_d;
         loop_cnt_q   <= loop_cnt_d;
         load_count_q <= load_count_d;
         drain_cnt_q  <= drain_cnt_d;
         load_done_q  <= load_done_d;
         play_done_q  <= play_done_d;
      end
   end

   // Read-valid pipeline mirrors the BRAM latency so dac_valid lines up with bram_dout.
   assign rv_d[0] = rd_issue;
   for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rv
      assign rv_d[gi] = rv_q[gi-1];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rv_q <= '0;
      end else begin
         rv_q <= rv_d;
      end
   end

   assign dac_valid_o  = rv_q[RD_LAT-1];
   assign dac_data_o   = dac_valid_o ? {~bram_dout_i[11], bram_dout_i[10:0]} : 12'h800;
   assign busy_o       = (state_q != S_IDLE);
   assign load_done_o  = load_done_q;
   assign play_done_o  = play_done_q;
   assign load_count_o = load_count_q;

endmodule
